// File: rtl/ddiff_sched.sv
// Shared sign-magnitude delayed-difference datapath, round-robin
// time-shared among NCH sample channels; results tagged with channel.
module ddiff_sched #(
    parameter  int NCH = 4,
    parameter  int W   = 16,
    localparam int CW  = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [NCH-1:0]   in_valid,
    output logic [NCH-1:0]   in_ready,
    input  logic [NCH*W-1:0] in_mag,
    input  logic [NCH-1:0]   in_sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_ch,
    output logic [W-1:0]     out_mag,
    output logic             out_sign,
    output logic             out_sat
);

    logic [NCH-1:0][W:0] prev_q, prev_d;
    logic [CW-1:0]       rr_q, rr_d;
    logic                out_valid_q, out_valid_d;
    logic [CW-1:0]       out_ch_q, out_ch_d;
    logic [W-1:0]        out_mag_q, out_mag_d;
    logic                out_sign_q, out_sign_d;
    logic                out_sat_q, out_sat_d;

    logic          slot_free;
    logic          gnt_vld;
    logic [CW-1:0] gnt;
    logic [CW-1:0] idx;
    logic          take;

    assign slot_free = !out_valid_q || out_ready;

    // Round-robin search starting at rr_q, wrapping modulo NCH
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        idx     = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = CW'((int'(rr_q) + k) % NCH);
            if (!gnt_vld && in_valid[idx]) begin
                gnt_vld = 1'b1;
                gnt     = idx;
            end
        end
    end

    assign take = rst_n && slot_free && !clr && gnt_vld;

    always_comb begin
        in_ready = '0;
        if (take) begin
            in_ready[gnt] = 1'b1;
        end
    end

    logic [W-1:0] a_mag;
    logic         a_sgn_raw;
    logic         a_sgn;
    logic [W:0]   b_word;
    logic [W-1:0] b_mag;
    logic         b_sgn;
    logic [W:0]   sum;
    logic [W-1:0] diff;
    logic [W:0]   res_mag;
    logic         res_sgn;
    logic         res_sat;
    logic [W-1:0] fin_mag;
    logic         fin_sgn;

    always_comb begin
        a_mag     = '0;
        a_sgn_raw = 1'b0;
        b_word    = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt == CW'(i)) begin
                a_mag     = in_mag[i*W +: W];
                a_sgn_raw = in_sign[i];
                b_word    = prev_q[i];
            end
        end
    end

    // A -0 input behaves as +0 both in this result and in stored history
    assign a_sgn = a_sgn_raw && (a_mag != '0);
    assign b_mag = b_word[W-1:0];
    assign b_sgn = b_word[W];

    always_comb begin
        sum     = {1'b0, a_mag} + {1'b0, b_mag};
        diff    = (a_mag >= b_mag) ? (a_mag - b_mag) : (b_mag - a_mag);
        res_mag = sum;
        res_sgn = a_sgn;
        if (a_sgn == b_sgn) begin
            res_mag = {1'b0, diff};
            res_sgn = b_sgn ? (a_mag > b_mag) : (a_mag < b_mag);
        end
        res_sat = res_mag[W];
        fin_mag = res_sat ? '1 : res_mag[W-1:0];
        fin_sgn = res_sgn && (res_mag != '0);
    end

    always_comb begin
        prev_d      = prev_q;
        rr_d        = rr_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        out_mag_d   = out_mag_q;
        out_sign_d  = out_sign_q;
        out_sat_d   = out_sat_q;
        if (clr) begin
            prev_d      = '0;
            rr_d        = '0;
            out_valid_d = 1'b0;
        end else if (take) begin
            prev_d[gnt] = {a_sgn, a_mag};
            rr_d        = (int'(gnt) == NCH - 1) ? '0 : gnt + 1'b1;
            out_valid_d = 1'b1;
            out_ch_d    = gnt;
            out_mag_d   = fin_mag;
            out_sign_d  = fin_sgn;
            out_sat_d   = res_sat;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q      <= '0;
            rr_q        <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_mag_q   <= '0;
            out_sign_q  <= 1'b0;
            out_sat_q   <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_mag_q   <= out_mag_d;
            out_sign_q  <= out_sign_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_mag   = out_mag_q;
    assign out_sign  = out_sign_q;
    assign out_sat   = out_sat_q;

    // Sources must hold a presented sample until it is accepted
    for (genvar i = 0; i < NCH; i++) begin : g_src
        a_hold: assert property (
            @(posedge clk) disable iff (!rst_n)
            in_valid[i] && !in_ready[i] |=>
                in_valid[i] && $stable(in_mag[i*W +: W]) &&
                $stable(in_sign[i]));
    end

    a_onehot: assert property (
        @(posedge clk) disable iff (!rst_n) $onehot0(in_ready));

    a_out_hold: assert property (
        @(posedge clk) disable iff (!rst_n)
        out_valid && !out_ready && !clr |=>
            out_valid && $stable(out_mag) && $stable(out_ch) &&
            $stable(out_sign) && $stable(out_sat));

endmodule

// File: tb/tb_ddiff_sched.sv
// Bench for ddiff_sched: directed vector table, then random traffic
// against an arithmetic reference model.
module tb_ddiff_sched;

    localparam int NCH = 4;
    localparam int W   = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [63:0] in_mag;
    logic [3:0]  in_sign;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ch;
    logic [15:0] out_mag;
    logic        out_sign;
    logic        out_sat;

    ddiff_sched #(.NCH(NCH), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mag    (in_mag),
        .in_sign   (in_sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_mag   (out_mag),
        .out_sign  (out_sign),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  vld;
        logic [63:0] mag;
        logic [3:0]  sg;
        bit          ordy;
        bit          clr;
        bit          rst;
        logic [3:0]  rdy;
        bit          ov;
        int          ch;
        int          mg;
        bit          s;
        bit          st;
    } vec_t;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    // Reference model state: history as signed integers
    int m_prev[NCH];
    int m_rr;
    bit m_ov;
    int m_ch;
    int m_mag;
    bit m_sgn;
    bit m_sat;

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic void mdl_reset();
        for (int i = 0; i < NCH; i++) m_prev[i] = 0;
        m_rr  = 0;
        m_ov  = 0;
        m_ch  = 0;
        m_mag = 0;
        m_sgn = 0;
        m_sat = 0;
    endfunction

    function automatic int mdl_grant();
        if (!rst_n || clr || (m_ov && !out_ready)) return -1;
        for (int k = 0; k < NCH; k++) begin
            if (in_valid[(m_rr + k) % NCH]) return (m_rr + k) % NCH;
        end
        return -1;
    endfunction

    function automatic void mdl_update(input int g);
        int a;
        int c;
        int ac;
        int mg;
        if (!rst_n) begin
            mdl_reset();
        end else if (clr) begin
            for (int i = 0; i < NCH; i++) m_prev[i] = 0;
            m_rr = 0;
            m_ov = 0;
        end else if (g >= 0) begin
            mg = int'(in_mag[g*W +: W]);
            a  = in_sign[g] ? -mg : mg;
            c  = a - m_prev[g];
            ac = (c < 0) ? -c : c;
            m_sat = ac > 65535;
            m_mag = m_sat ? 65535 : ac;
            m_sgn = c < 0;
            m_ch  = g;
            m_prev[g] = a;
            m_rr  = (g + 1) % NCH;
            m_ov  = 1;
        end else if (m_ov && out_ready) begin
            m_ov = 0;
        end
    endfunction

    task automatic drive(input vec_t t);
        in_valid  = t.vld;
        in_mag    = t.mag;
        in_sign   = t.sg;
        out_ready = t.ordy;
        clr       = t.clr;
        rst_n     = !t.rst;
        if (t.rst) mdl_reset();
    endtask

    task automatic run_cyc(input bit use_tab, input vec_t t,
                           output int g);
        @(negedge clk);
        g = mdl_grant();
        if (use_tab) begin
            chk("in_ready", int'(in_ready), int'(t.rdy));
            chk("out_valid", int'(out_valid), int'(t.ov));
            if (t.ov || t.rst) begin
                chk("out_ch", int'(out_ch), t.ch);
                chk("out_mag", int'(out_mag), t.mg);
                chk("out_sign", int'(out_sign), int'(t.s));
                chk("out_sat", int'(out_sat), int'(t.st));
            end
        end else begin
            chk("rnd_ready", int'(in_ready), (g >= 0) ? (1 << g) : 0);
            chk("rnd_valid", int'(out_valid), int'(m_ov));
            if (m_ov) begin
                chk("rnd_ch", int'(out_ch), m_ch);
                chk("rnd_mag", int'(out_mag), m_mag);
                chk("rnd_sign", int'(out_sign), int'(m_sgn));
                chk("rnd_sat", int'(out_sat), int'(m_sat));
            end
        end
        @(posedge clk);
        mdl_update(g);
        cyc++;
        #1;
    endtask

    function automatic vec_t rw(
        input logic [3:0] vld,
        input logic [15:0] m0, m1, m2, m3,
        input logic [3:0] sg,
        input bit ordy, input bit cl, input bit rs,
        input logic [3:0] rdy,
        input bit ov, input int ch, input int mg,
        input bit s, input bit st);
        vec_t r;
        r.vld = vld;
        r.mag = {m3, m2, m1, m0};
        r.sg  = sg;
        r.ordy = ordy;
        r.clr = cl;
        r.rst = rs;
        r.rdy = rdy;
        r.ov  = ov;
        r.ch  = ch;
        r.mg  = mg;
        r.s   = s;
        r.st  = st;
        return r;
    endfunction

    function automatic vec_t idle(input bit ov, input int ch,
                                  input int mg, input bit s);
        return rw(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, ov, ch, mg, s, 0);
    endfunction

    vec_t tab[$];
    bit          pend[NCH];
    logic [15:0] pmag[NCH];
    bit          psgn[NCH];

    initial begin
        int   g;
        vec_t v;

        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 4'hF;
        in_mag    = '0;
        in_sign   = '0;
        out_ready = 1'b1;
        mdl_reset();
        #2;
        chk("rst_ready", int'(in_ready), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_mag", int'(out_mag), 0);
        chk("rst_ch", int'(out_ch), 0);
        chk("rst_sign_sat", int'({out_sign, out_sat}), 0);
        in_valid = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ch0 basic differences
        tab.push_back(rw(1, 100, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tab.push_back(rw(1, 30, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 100, 0, 0));
        tab.push_back(rw(1, 20, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 70, 1, 0));
        tab.push_back(idle(1, 0, 50, 1));
        tab.push_back(idle(0, 0, 0, 0));
        // ch1 saturation and zero normalisation
        tab.push_back(rw(2, 0, 16'hF000, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0, 0, 0));
        tab.push_back(rw(2, 0, 16'h2000, 0, 0, 2, 1, 0, 0, 2,
                         1, 1, 16'hF000, 0, 0));
        tab.push_back(rw(2, 0, 16'h2000, 0, 0, 2, 1, 0, 0, 2,
                         1, 1, 16'hFFFF, 1, 1));
        tab.push_back(idle(1, 1, 0, 0));
        tab.push_back(idle(0, 0, 0, 0));
        // ch2 -5,-5 and ch3 -0
        tab.push_back(rw(4, 0, 0, 5, 0, 4, 1, 0, 0, 4, 0, 0, 0, 0, 0));
        tab.push_back(rw(4, 0, 0, 5, 0, 4, 1, 0, 0, 4, 1, 2, 5, 1, 0));
        tab.push_back(rw(8, 0, 0, 0, 0, 8, 1, 0, 0, 8, 1, 2, 0, 0, 0));
        tab.push_back(idle(1, 3, 0, 0));
        tab.push_back(idle(0, 0, 0, 0));
        // backpressure for three cycles
        tab.push_back(rw(1, 10, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            tab.push_back(rw(3, 5, 16'h100, 0, 0, 0, 0, 0, 0, 0,
                             1, 0, 30, 0, 0));
        tab.push_back(rw(3, 5, 16'h100, 0, 0, 0, 1, 0, 0, 2, 1, 0, 30, 0, 0));
        tab.push_back(rw(1, 5, 0, 0, 0, 0, 1, 0, 0, 1,
                         1, 1, 16'h2100, 0, 0));
        tab.push_back(idle(1, 0, 5, 1));
        tab.push_back(idle(0, 0, 0, 0));
        // clear history, then all four channels continuously
        tab.push_back(rw(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        tab.push_back(rw(15, 1, 2, 3, 4, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tab.push_back(rw(15, 11, 2, 3, 4, 0, 1, 0, 0, 2, 1, 0, 1, 0, 0));
        tab.push_back(rw(15, 11, 12, 3, 4, 0, 1, 0, 0, 4, 1, 1, 2, 0, 0));
        tab.push_back(rw(15, 11, 12, 13, 4, 0, 1, 0, 0, 8, 1, 2, 3, 0, 0));
        tab.push_back(rw(15, 11, 12, 13, 14, 0, 1, 0, 0, 1, 1, 3, 4, 0, 0));
        tab.push_back(rw(14, 0, 12, 13, 14, 0, 1, 0, 0, 2, 1, 0, 10, 0, 0));
        tab.push_back(rw(12, 0, 0, 13, 14, 0, 1, 0, 0, 4, 1, 1, 10, 0, 0));
        tab.push_back(rw(8, 0, 0, 0, 14, 0, 1, 0, 0, 8, 1, 2, 10, 0, 0));
        tab.push_back(idle(1, 3, 10, 0));
        tab.push_back(idle(0, 0, 0, 0));
        // clr drops a pending result
        tab.push_back(rw(4, 0, 0, 13, 0, 0, 1, 0, 0, 4, 0, 0, 0, 0, 0));
        tab.push_back(rw(1, 7, 0, 0, 0, 0, 1, 1, 0, 0, 1, 2, 0, 0, 0));
        tab.push_back(rw(1, 7, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tab.push_back(idle(1, 0, 7, 0));
        tab.push_back(idle(0, 0, 0, 0));
        // async reset drops a pending result
        tab.push_back(rw(4, 0, 0, 9, 0, 0, 1, 0, 0, 4, 0, 0, 0, 0, 0));
        tab.push_back(rw(1, 7, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        tab.push_back(rw(1, 7, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tab.push_back(idle(1, 0, 7, 0));
        tab.push_back(idle(0, 0, 0, 0));

        foreach (tab[i]) begin
            drive(tab[i]);
            run_cyc(1'b1, tab[i], g);
        end

        // Random traffic against the model
        v = rw(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        drive(v);
        run_cyc(1'b0, v, g);
        rst_n = 1'b1;
        for (int i = 0; i < NCH; i++) pend[i] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NCH; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1;
                    case ($urandom_range(0, 3))
                        0:       pmag[i] = 16'h0000;
                        1:       pmag[i] = 16'hFFFF;
                        default: pmag[i] = 16'($urandom);
                    endcase
                    psgn[i] = 1'($urandom);
                end
                in_valid[i]      = pend[i];
                in_mag[i*W +: W] = pmag[i];
                in_sign[i]       = psgn[i];
            end
            out_ready = ($urandom_range(0, 9) < 7);
            clr       = ($urandom_range(0, 49) == 0);
            run_cyc(1'b0, v, g);
            if (g >= 0) pend[g] = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ddiff_sched.md
Name: ddiff_sched

Overview:
- Time-shares one registered sign-magnitude delayed-difference datapath among NCH sample channels.
- Each channel gets C = A(n) - A(n-1), where A(n-1) is that channel's previous accepted sample.
- Sits between the per-channel sample sources and the noise-shaping PWM loops.
- Replaces one differencer instance per channel; results are tagged with the channel index.

Parameters:
- NCH, 4, number of requesting channels (2..16).
- W, 16, magnitude width in bits.
- CW, $clog2(NCH), channel index width (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous clear of channel history.
- in_valid  in  NCH  per-channel sample valid.
- in_ready  out  NCH  per-channel accept (one-hot or zero).
- in_mag  in  NCH*W  packed magnitudes; channel i occupies [i*W +: W].
- in_sign  in  NCH  per-channel sign; 1 = negative.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_ch  out  CW  channel index of the result.
- out_mag  out  W  |C|.
- out_sign  out  1  sign of C; 1 = negative.
- out_sat  out  1  magnitude saturated.

Behaviour:
- Reset (rst_n low, async):
  - all prev_mag[i] = 0, prev_sign[i] = 0; rr pointer = 0.
  - out_valid, out_ch, out_mag, out_sign, out_sat = 0.
  - in_ready = 0 while rst_n is low.
  - Reset mid-transfer discards the pending output without a handshake.
- Slot availability: slot_free = !out_valid || out_ready.
- Arbitration (combinational):
  - If slot_free and !clr, grant the first channel with in_valid set, searching from rr upward modulo NCH.
  - in_ready[g] = 1 for the granted channel only. in_ready does not depend on in_valid of other channels beyond the search.
  - A transfer occurs when in_valid[g] && in_ready[g].
- On a transfer at edge n:
  - prev[g] <= {in_sign[g], in_mag[g]}.
  - Output register loads {g, C, sat}; out_valid = 1 after edge n.
  - rr <= (g+1) mod NCH.
  - Latency is 1 cycle from acceptance to out_valid.
- If out_valid && out_ready and there is no transfer: out_valid <= 0.
- Back-to-back operation: an output is consumed and a new sample accepted in the same cycle, giving full throughput of 1 sample/cycle.
- If out_valid && !out_ready:
  - out_* hold stable; no grant; prev and rr unchanged.
- Arithmetic: C = A - B in sign-magnitude, with B = prev[g] and an internal W+1 bit sum.
  - Same signs: result magnitude = |A-B|.
    - A,B both positive: sign = (A < B).
    - Both negative: sign = (A > B).
  - Different signs: result magnitude = A+B, sign = A_sign.
  - If magnitude > 2^W-1: out_mag = 2^W-1, out_sat = 1; otherwise out_sat = 0.
  - Zero normalisation:
    - A zero result always has out_sign = 0.
    - An input of magnitude 0 with sign 1 is treated as +0 and stored as prev sign 0.
- clr (synchronous, has priority over arbitration):
  - That cycle: all prev = +0, rr = 0, in_ready = 0, out_valid <= 0.
  - The pending output is dropped.
- Channels not granted hold their sample; once presented, in_valid must stay asserted with data stable until accepted (source rule, checked by assertion).
- Starvation bound: a channel that stays valid is granted within NCH accepted transfers.

Test Plan:
- Ch0 only, out_ready=1, samples +100, +30, -20 -> outputs (ch0,100,+), (ch0,70,-), (ch0,50,-), each one cycle after acceptance, out_sat=0.
- Ch1 samples +0xF000 then -0x2000 -> second result mag 0xFFFF, sign 1, sat 1; third sample -0x2000 -> mag 0, sign 0.
- All four channels valid continuously, out_ready=1 -> grant order 0,1,2,3,0,1; out_valid high every cycle; each channel's result uses its own history.
- Result pending, out_ready=0 for 3 cycles -> out_* stable, in_ready=0, prev unchanged; on release, next grant goes to the rr-pointed channel.
- Ch2 samples -5 then -5, and ch3 samples with mag 0 sign 1 -> ch2 result (0,+); ch3 result from +0 history is (0,+).
- clr with result pending and ch0 valid -> out_valid 0 next cycle, no grant that cycle; next ch0 sample +7 yields (7,+). Repeating the same check with rst_n pulsed low mid-stream gives the same result.
